serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Sequences one 1-bit full-adder cell over

---
 rtl/serial_add_ctrl.sv | 68 ++++++
 tb/tb_serial_add_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder cell stepped LSB first over WIDTH bits
// with a registered carry and a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nx;
    logic           c, s, c_nx;
    always_comb begin
        s    = a_sr[0] ^ b_sr[0] ^ c;
        c_nx = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & c);
        r_nx = {s, r_sr[WIDTH-1:1]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == IDLE || state == DONE) && start) begin
                a_sr  <= a;
                b_sr  <= b;
                c     <= cin;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                c    <= c_nx;
                r_sr <= r_nx;
                cnt  <= cnt + 1'b1;
                // last bit: publish the assembled result together with the final carry
                if (cnt == CW'(WIDTH - 1)) begin
                    sum   <= r_nx;
                    carry <= c_nx;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of the 8-bit serial adder and an exhaustive 4-bit sweep.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0, sum;
    logic       busy, done, carry;
    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, carry4;
    int         checks = 0, failures = 0;
    logic [8:0] held = '0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );
    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge (IDLE or DONE); returns #1 after the completing edge.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [8:0] exp, input logic poke);
        a = ta; b = tb; cin = tc; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("run_busy", {31'd0, busy}, 32'd1);
            chk("run_done", {31'd0, done}, 32'd0);
            chk("run_hold", {23'd0, carry, sum}, {23'd0, held});
            start = poke && (i == 2 || i == 4);
            a = ~ta; b = ~tb;
            step();
        end
        start = 1'b0;
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_busy", {31'd0, busy}, 32'd0);
        chk("fin_result", {23'd0, carry, sum}, {23'd0, exp});
        held = exp;
    endtask

    initial begin
        #12 rst = 1'b0;
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {23'd0, carry, sum}, 32'd0);

        // FF + 01 wraps into carry
        op8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        step();
        chk("done_width", {31'd0, done}, 32'd0);
        chk("idle_hold", {23'd0, carry, sum}, 32'h100);

        // async reset with no clock edge clears outputs immediately
        rst = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_result", {23'd0, carry, sum}, 32'd0);
        rst = 1'b0;
        held = '0;
        step();

        // start pulses during RUN are ignored
        op8(8'h5A, 8'h3C, 1'b1, 9'h097, 1'b1);
        step();
        chk("done_width3", {31'd0, done}, 32'd0);
        chk("no_restart", {31'd0, busy}, 32'd0);

        // reset in the 4th RUN cycle aborts without a done pulse
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        held = '0;
        chk("abort_result", {23'd0, carry, sum}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_nodone", {31'd0, done}, 32'd0);
        end
        op8(8'h01, 8'h01, 1'b0, 9'h002, 1'b0);
        // back-to-back: start already presented in DONE
        op8(8'h80, 8'h80, 1'b0, 9'h100, 1'b0);
        step();
        chk("b2b_done_width", {31'd0, done}, 32'd0);

        // exhaustive WIDTH=4 sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int z = 0; z < 2; z++) begin
                    a4 = 4'(x); b4 = 4'(y); cin4 = z[0]; start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    chk("w4_busy", {31'd0, busy4}, 32'd1);
                    step(); step(); step();
                    chk("w4_early", {31'd0, done4}, 32'd0);
                    step();
                    chk("w4_done", {31'd0, done4}, 32'd1);
                    chk("w4_result", {27'd0, carry4, sum4}, 32'(x + y + z));
                    step();
                    chk("w4_width", {31'd0, done4}, 32'd0);
                end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
